// File: rtl/gvram_dot_seq.sv
// Dot/byte sequencer for the GVRAM display path: dot counter, shift enables, byte loads, fetch address.
// Latency: DOT_EN/LOAD combinational from BLANK and state; CNT/ADDR update on the clock; LINE_END one clock after BLANK rises.
// Backpressure: none; the downstream shift register consumes every DOT_EN and LOAD.
module gvram_dot_seq #(
   parameter int CNT_W  = 3,
   parameter int ADDR_W = 13,
   parameter int PRE_W  = 2,
   parameter int PHASE  = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              BLANK,
   input  logic              VSTART,
   input  logic [ADDR_W-1:0] BASE,
   input  logic [ADDR_W-1:0] STRIDE,
   input  logic [PRE_W-1:0]  DIV,
   output logic [CNT_W-1:0]  CNT,
   output logic              DOT_EN,
   output logic              LOAD,
   output logic [ADDR_W-1:0] ADDR,
   output logic              LINE_END
);

   localparam logic [CNT_W-1:0] CNT_PHASE = CNT_W'(PHASE);
   localparam logic [CNT_W-1:0] CNT_LAST  = '1;

   logic [PRE_W-1:0]  pre;
   logic [ADDR_W-1:0] line_base;
   logic [ADDR_W-1:0] next_line;
   logic              blank_d;
   logic              tick;
   logic              line_done;

   // >= rather than == so a DIV lowered mid-line takes effect without waiting for a prescaler wrap
   assign tick      = ~BLANK & (pre >= DIV);
   assign DOT_EN    = tick;
   // LOAD marks the last dot of a byte; a byte cut short by BLANK never raises it
   assign LOAD      = tick & (CNT == CNT_LAST);
   assign line_done = BLANK & ~blank_d;
   assign next_line = line_base + STRIDE;

   // Prescaler: cleared in blanking and on every dot advance, otherwise counts clocks
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         pre <= '0;
      else if (BLANK || tick)
         pre <= '0;
      else
         pre <= pre + PRE_W'(1);
   end

   // Dot counter: parked at the alignment phase in blanking, steps on each tick in active video
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         CNT <= CNT_PHASE;
      else if (BLANK)
         CNT <= CNT_PHASE;
      else if (tick)
         CNT <= CNT + CNT_W'(1);
   end

   // Fetch address: frame rebase beats line advance, which beats the per-byte increment
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         line_base <= '0;
         ADDR      <= '0;
      end else if (VSTART) begin
         line_base <= BASE;
         ADDR      <= BASE;
      end else if (line_done) begin
         line_base <= next_line;
         ADDR      <= next_line;
      end else if (LOAD) begin
         ADDR      <= ADDR + ADDR_W'(1);
      end
   end

   // Blank edge detect; blank_d resets high so leaving reset inside blanking is not a line end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         blank_d  <= 1'b1;
         LINE_END <= 1'b0;
      end else begin
         blank_d  <= BLANK;
         LINE_END <= line_done;
      end
   end

endmodule

// File: tb/tb_gvram_dot_seq.sv
// Bench for gvram_dot_seq: directed vectors with hand-derived expectations pushed to a scoreboard.
// Two instances share stimulus: u0 with PHASE=0, u1 with PHASE=5.
// A negedge monitor pops every expectation queued for the current cycle and compares.
module tb_gvram_dot_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        BLANK = 1'b1;
   logic        VSTART = 1'b0;
   logic [12:0] BASE = '0;
   logic [12:0] STRIDE = '0;
   logic [1:0]  DIV = '0;

   logic [2:0]  cnt0, cnt1;
   logic        dot0, dot1, load0, load1, lend0, lend1;
   logic [12:0] addr0, addr1;

   gvram_dot_seq #(.CNT_W(3), .ADDR_W(13), .PRE_W(2), .PHASE(0)) u0 (
      .CLK(CLK), .RST(RST), .BLANK(BLANK), .VSTART(VSTART), .BASE(BASE), .STRIDE(STRIDE),
      .DIV(DIV), .CNT(cnt0), .DOT_EN(dot0), .LOAD(load0), .ADDR(addr0), .LINE_END(lend0));

   gvram_dot_seq #(.CNT_W(3), .ADDR_W(13), .PRE_W(2), .PHASE(5)) u1 (
      .CLK(CLK), .RST(RST), .BLANK(BLANK), .VSTART(VSTART), .BASE(BASE), .STRIDE(STRIDE),
      .DIV(DIV), .CNT(cnt1), .DOT_EN(dot1), .LOAD(load1), .ADDR(addr1), .LINE_END(lend1));

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [15:0] tag;
      logic        sel;
      logic [4:0]  m;
      logic [2:0]  cnt;
      logic        dot;
      logic        load;
      logic [12:0] addr;
      logic        lend;
   } exp_t;

   localparam logic [4:0] M_CNT  = 5'b10000;
   localparam logic [4:0] M_DOT  = 5'b01000;
   localparam logic [4:0] M_LOAD = 5'b00100;
   localparam logic [4:0] M_ADDR = 5'b00010;
   localparam logic [4:0] M_LEND = 5'b00001;
   localparam logic [4:0] M_ALL  = 5'b11111;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s tag=%0d actual=0x%0h required=0x%0h", nm, tag, act, req);
      end
   endtask

   task automatic push(input int tag, input logic sel, input logic [4:0] m, input int c,
                       input logic d, input logic l, input int a, input logic le);
      exp_t e;
      e.tag  = 16'(tag);
      e.sel  = sel;
      e.m    = m;
      e.cnt  = 3'(c);
      e.dot  = d;
      e.load = l;
      e.addr = 13'(a);
      e.lend = le;
      sb.push_back(e);
   endtask

   // Advance one clock, then present the next cycle's BLANK/VSTART
   task automatic cyc(input logic b, input logic v);
      @(posedge CLK);
      #1;
      BLANK  = b;
      VSTART = v;
   endtask

   // Monitor: compare everything expected for this cycle, away from the active edge
   always @(negedge CLK) begin : monitor
      exp_t        e;
      logic [2:0]  ac;
      logic        ad, al, ale;
      logic [12:0] aa;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.sel) begin
            ac = cnt1; ad = dot1; al = load1; aa = addr1; ale = lend1;
         end else begin
            ac = cnt0; ad = dot0; al = load0; aa = addr0; ale = lend0;
         end
         if (e.m[4]) cmp("cnt",      int'(e.tag), 32'(ac),  32'(e.cnt));
         if (e.m[3]) cmp("dot_en",   int'(e.tag), 32'(ad),  32'(e.dot));
         if (e.m[2]) cmp("load",     int'(e.tag), 32'(al),  32'(e.load));
         if (e.m[1]) cmp("addr",     int'(e.tag), 32'(aa),  32'(e.addr));
         if (e.m[0]) cmp("line_end", int'(e.tag), 32'(ale), 32'(e.lend));
      end
   end

   initial begin
      // Reset state, held and just after release inside blanking
      cyc(1, 0);
      push(100, 0, M_ALL, 0, 0, 0, 0, 0);
      push(101, 1, M_CNT | M_ADDR | M_LEND, 5, 0, 0, 0, 0);
      cyc(1, 0);
      RST = 1'b0;
      push(102, 0, M_ALL, 0, 0, 0, 0, 0);
      cyc(1, 0);
      push(103, 0, M_ALL, 0, 0, 0, 0, 0);

      // DIV=0: CNT steps every clock, LOAD on clocks 7 and 15
      BASE = 13'h100; STRIDE = 13'h050; DIV = 2'd0;
      cyc(1, 1);
      for (int k = 0; k < 16; k++) begin
         cyc(0, 0);
         push(1000 + k, 0, M_ALL, k % 8, 1, (k % 8) == 7, 'h100 + k / 8, 0);
      end
      cyc(1, 0);
      push(1100, 0, M_ALL, 0, 0, 0, 'h102, 0);
      cyc(1, 0);
      push(1101, 0, M_CNT | M_ADDR | M_LEND, 0, 0, 0, 'h150, 1);
      cyc(1, 0);
      push(1102, 0, M_ADDR | M_LEND, 0, 0, 0, 'h150, 0);

      // DIV=1: DOT_EN on odd clocks only, single LOAD on clock 15
      BASE = 13'h200; DIV = 2'd1;
      cyc(1, 1);
      for (int k = 0; k < 16; k++) begin
         cyc(0, 0);
         push(2000 + k, 0, M_ALL, k / 2, (k % 2) == 1, k == 15, 'h200, 0);
      end
      cyc(1, 0);
      push(2100, 0, M_ALL, 0, 0, 0, 'h201, 0);
      cyc(1, 0);
      push(2101, 0, M_ADDR | M_LEND, 0, 0, 0, 'h250, 1);

      // Two lines of 40 bytes with STRIDE 0x50
      BASE = 13'h100; DIV = 2'd0;
      cyc(1, 1);
      for (int ln = 0; ln < 2; ln++) begin
         for (int k = 0; k < 320; k++) begin
            cyc(0, 0);
            push(3000 + ln * 1000 + k, 0, M_ALL, k % 8, 1, (k % 8) == 7, 'h100 + ln * 'h50 + k / 8, 0);
         end
         cyc(1, 0);
         push(3400 + ln * 1000, 0, M_ADDR | M_LEND | M_DOT, 0, 0, 0, 'h128 + ln * 'h50, 0);
         cyc(1, 0);
         push(3401 + ln * 1000, 0, M_ADDR | M_LEND, 0, 0, 0, 'h150 + ln * 'h50, 1);
         cyc(1, 0);
         push(3402 + ln * 1000, 0, M_LEND, 0, 0, 0, 0, 0);
      end

      // VSTART coincident with line_done
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0);
         push(4000 + k, 0, M_ALL, k, 1, 0, 'h1A0, 0);
      end
      BASE = 13'h300;
      cyc(1, 1);
      push(4100, 0, M_ALL, 4, 0, 0, 'h1A0, 0);
      cyc(1, 0);
      push(4101, 0, M_ADDR | M_LEND, 0, 0, 0, 'h300, 1);
      cyc(1, 0);
      push(4102, 0, M_ADDR | M_LEND, 0, 0, 0, 'h300, 0);

      // VSTART coincident with LOAD
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin
            BASE = 13'h340;
            cyc(0, 1);
         end else begin
            cyc(0, 0);
         end
         push(4200 + k, 0, M_ALL, k, 1, k == 7, 'h300, 0);
      end
      cyc(0, 0);
      push(4208, 0, M_CNT | M_LOAD | M_ADDR, 0, 1, 0, 'h340, 0);
      cyc(1, 0);
      push(4300, 0, M_ADDR | M_LEND, 0, 0, 0, 'h340, 0);
      cyc(1, 0);
      push(4301, 0, M_ADDR | M_LEND, 0, 0, 0, 'h390, 1);

      // PHASE=5 instance: early LOAD, then a byte truncated by BLANK
      BASE = 13'h400;
      cyc(1, 1);
      for (int k = 0; k < 6; k++) begin
         cyc(0, 0);
         push(5000 + k, 1, M_ALL, (5 + k) % 8, 1, k == 2, (k >= 3) ? 'h401 : 'h400, 0);
      end
      cyc(1, 0);
      push(5100, 1, M_ALL, 3, 0, 0, 'h401, 0);
      cyc(1, 0);
      push(5101, 1, M_ALL, 5, 0, 0, 'h450, 1);

      // Asynchronous reset in the middle of a line
      BASE = 13'h120;
      cyc(1, 1);
      for (int k = 0; k < 29; k++) begin
         cyc(0, 0);
         push(6000 + k, 0, M_ALL, k % 8, 1, (k % 8) == 7, 'h120 + k / 8, 0);
      end
      @(posedge CLK);
      #1;
      RST = 1'b1;
      push(6100, 0, M_CNT | M_LOAD | M_ADDR | M_LEND, 0, 0, 0, 0, 0);
      push(6101, 1, M_CNT | M_ADDR | M_LEND, 5, 0, 0, 0, 0);
      cyc(1, 0);
      push(6102, 0, M_ALL, 0, 0, 0, 0, 0);
      cyc(1, 0);
      RST = 1'b0;
      cyc(1, 0);
      push(6103, 0, M_ALL, 0, 0, 0, 0, 0);

      // Every queued expectation must have been consumed by the monitor
      @(posedge CLK);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
